// File: rtl/sie_tx_sequencer.sv
// sie_tx_sequencer: turns token / data / handshake requests into a timed byte
// schedule (SYNC, PID, payload) for the SIE wrapper, one byte per BYTE_PERIOD
// clocks, each with a one-clock load_SIE strobe, followed by GAP_SLOTS idle slots.
// Optional build macro SIE_SEQ_CRC16_PAD_EN: when defined, data packets append
// two zero CRC16 pad bytes; when undefined they end after the last DATA byte.
module sie_tx_sequencer #(
  parameter int BYTE_PERIOD = 8,
  parameter int GAP_SLOTS   = 2,
  parameter int LEN_W       = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [3:0]       req_pid,
  input  logic [6:0]       req_addr,
  input  logic [3:0]       req_endp,
  input  logic [LEN_W-1:0] req_len,
  input  logic             dat_valid,
  input  logic [7:0]       dat_byte,
  output logic             dat_ready,
  output logic             load_SIE,
  output logic [7:0]       parallel_ip,
  output logic             busy,
  output logic             done,
  output logic             seq_error
);

  localparam int CNT_W = $clog2(BYTE_PERIOD);
  localparam int GAP_W = (GAP_SLOTS > 1) ? $clog2(GAP_SLOTS) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(BYTE_PERIOD - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_SLOTS > 0) ? GAP_SLOTS - 1 : 0);
  localparam logic [7:0]       SYNC_BYTE = 8'b1000_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_PID, S_TOK1, S_TOK2, S_DATA, S_CRC1, S_CRC2, S_GAP
  } state_e;

  typedef enum logic [1:0] {
    K_TOKEN = 2'b00, K_DATA = 2'b01, K_HAND = 2'b10, K_RSVD = 2'b11
  } kind_e;

  // Where a packet goes once its last byte slot ends.
  localparam state_e END_STATE = (GAP_SLOTS == 0) ? S_IDLE : S_GAP;

`ifdef SIE_SEQ_CRC16_PAD_EN
  localparam state_e AFTER_DATA = S_CRC1;
`else
  localparam state_e AFTER_DATA = S_GAP;
`endif

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [3:0]       pid_q, pid_d;
  logic [6:0]       addr_q, addr_d;
  logic [3:0]       endp_q, endp_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             load_q, load_d;
  logic [7:0]       pip_q, pip_d;
  logic             err_q, err_d;

  state_e     nxt_byte;   // S_GAP here means "packet complete"
  logic [7:0] nxt_val;
  logic       slot_end;
  logic       in_bytes;

  assign slot_end = (cnt_q == SLOT_LAST);
  assign in_bytes = (state_q != S_IDLE) && (state_q != S_GAP);

  // Successor of the current byte state, decided from the captured request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    nxt_byte = S_GAP;
    unique case (state_q)
      S_SYNC: nxt_byte = S_PID;
      S_PID: begin
        unique case (kind_q)
          K_TOKEN: nxt_byte = S_TOK1;
          K_DATA:  nxt_byte = (rem_q != '0) ? S_DATA : AFTER_DATA;
          default: nxt_byte = S_GAP;
        endcase
      end
      S_TOK1: nxt_byte = S_TOK2;
      S_DATA: nxt_byte = (rem_q != '0) ? S_DATA : AFTER_DATA;
      S_CRC1: nxt_byte = S_CRC2;
      default: nxt_byte = S_GAP;
    endcase
  end

  // Byte value for the next non-payload slot.
  always_comb begin
    nxt_val = 8'h00;
    unique case (nxt_byte)
      S_PID:   nxt_val = {~pid_q, pid_q};
      S_TOK1:  nxt_val = {endp_q[0], addr_q};
      S_TOK2:  nxt_val = {5'b0_0000, endp_q[3:1]};
      default: nxt_val = 8'h00;
    endcase
  end

  // Next-state logic: request capture, slot timing, payload fetch and gap.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    pid_d   = pid_q;
    addr_d  = addr_q;
    endp_d  = endp_q;
    rem_d   = rem_q;
    load_d  = 1'b0;
    pip_d   = pip_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          kind_d = kind_e'(req_kind);
          pid_d  = req_pid;
          addr_d = req_addr;
          endp_d = req_endp;
          rem_d  = req_len;
          cnt_d  = '0;
          gap_d  = '0;
          if (kind_e'(req_kind) == K_RSVD) begin
            err_d = 1'b1;
          end else begin
            state_d = S_SYNC;
            load_d  = 1'b1;
            pip_d   = SYNC_BYTE;
          end
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (slot_end) begin
          cnt_d = '0;
          if (gap_q == GAP_LAST) begin
            state_d = S_IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (slot_end) begin
          cnt_d = '0;
          gap_d = '0;
          unique case (nxt_byte)
            S_GAP: state_d = END_STATE;
            S_DATA: begin
              if (dat_valid) begin
                state_d = S_DATA;
                load_d  = 1'b1;
                pip_d   = dat_byte;
                rem_d   = rem_q - 1'b1;
              end else begin
                // Underrun: abandon the packet without loading anything.
                state_d = END_STATE;
                err_d   = 1'b1;
              end
            end
            default: begin
              state_d = nxt_byte;
              load_d  = 1'b1;
              pip_d   = nxt_val;
            end
          endcase
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_TOKEN;
      cnt_q   <= '0;
      gap_q   <= '0;
      pid_q   <= '0;
      addr_q  <= '0;
      endp_q  <= '0;
      rem_q   <= '0;
      load_q  <= 1'b0;
      pip_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      pid_q   <= pid_d;
      addr_q  <= addr_d;
      endp_q  <= endp_d;
      rem_q   <= rem_d;
      load_q  <= load_d;
      pip_q   <= pip_d;
      err_q   <= err_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign dat_ready   = in_bytes && slot_end && (nxt_byte == S_DATA);
  assign done        = in_bytes && slot_end && (nxt_byte == S_GAP);
  assign load_SIE    = load_q;
  assign parallel_ip = pip_q;
  assign seq_error   = err_q;

endmodule

// File: tb/tb_sie_tx_sequencer.sv
// Scoreboard bench for sie_tx_sequencer: stimulus pushes expected loads,
// strobes and pulses into queues; a negedge monitor pops and compares them.
module tb_sie_tx_sequencer;

  localparam int LW = 7;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_kind = 2'b00;
  logic [3:0]    req_pid = 4'h0;
  logic [6:0]    req_addr = 7'h00;
  logic [3:0]    req_endp = 4'h0;
  logic [LW-1:0] req_len = '0;
  logic          dat_valid = 1'b0;
  logic [7:0]    dat_byte = 8'h00;
  logic          dat_ready;
  logic          load_SIE;
  logic [7:0]    parallel_ip;
  logic          busy;
  logic          done;
  logic          seq_error;

  sie_tx_sequencer #(.BYTE_PERIOD(8), .GAP_SLOTS(2), .LEN_W(LW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_pid(req_pid), .req_addr(req_addr), .req_endp(req_endp), .req_len(req_len),
    .dat_valid(dat_valid), .dat_byte(dat_byte), .dat_ready(dat_ready),
    .load_SIE(load_SIE), .parallel_ip(parallel_ip), .busy(busy),
    .done(done), .seq_error(seq_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] b; } load_t;
  typedef struct { logic v; logic [7:0] b; } pay_t;

  load_t exp_load[$];
  int    exp_done[$];
  int    exp_drdy[$];
  int    exp_err[$];
  pay_t  pay_q[$];

  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_ld(input int c, input logic [7:0] b);
    load_t e;
    e.cyc = c;
    e.b   = b;
    exp_load.push_back(e);
  endtask

  task automatic pay(input logic v, input logic [7:0] b);
    pay_t p;
    p.v = v;
    p.b = b;
    pay_q.push_back(p);
  endtask

  // Payload source: answers each fetch strobe with the next queued entry.
  always @(negedge clock) begin
    pay_t p;
    if (dat_ready === 1'b1 && pay_q.size() > 0) begin
      p = pay_q.pop_front();
      dat_valid = p.v;
      dat_byte  = p.b;
    end else begin
      dat_valid = 1'b0;
      dat_byte  = 8'h00;
    end
  end

  // Monitor: every observed strobe/pulse must match the head of its queue.
  always @(negedge clock) begin
    load_t e;
    int    c;
    if (mon_en) begin
      if (load_SIE === 1'b1) begin
        if (exp_load.size() == 0) check("load_unexpected", exp_load.size(), 1);
        else begin
          e = exp_load.pop_front();
          check("load_cycle", cyc, e.cyc);
          check("load_byte", parallel_ip, e.b);
        end
      end
      if (done === 1'b1) begin
        if (exp_done.size() == 0) check("done_unexpected", exp_done.size(), 1);
        else begin c = exp_done.pop_front(); check("done_cycle", cyc, c); end
      end
      if (dat_ready === 1'b1) begin
        if (exp_drdy.size() == 0) check("dat_ready_unexpected", exp_drdy.size(), 1);
        else begin c = exp_drdy.pop_front(); check("dat_ready_cycle", cyc, c); end
      end
      if (seq_error === 1'b1) begin
        if (exp_err.size() == 0) check("seq_error_unexpected", exp_err.size(), 1);
        else begin c = exp_err.pop_front(); check("seq_error_cycle", cyc, c); end
      end
    end
  end

  // Waits for an idle sequencer, then drives a request; returns the cycle
  // before the accepting edge (cycle 0) so the caller can push expectations.
  task automatic issue(input logic [1:0] kind, input logic [3:0] pid, input logic [6:0] addr,
                       input logic [3:0] endp, input logic [LW-1:0] len, output int base);
    int n = 0;
    @(negedge clock);
    while (req_ready !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("ready_before_issue", req_ready, 1);
    req_valid = 1'b1;
    req_kind  = kind;
    req_pid   = pid;
    req_addr  = addr;
    req_endp  = endp;
    req_len   = len;
    base      = cyc;
  endtask

  task automatic release_req();
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic expect_ready_at(input string name, input int want);
    int n = 0;
    while (req_ready !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    check(name, cyc, want);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int b;
    int rdy_hi;

    // Reset state.
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_load", load_SIE, 0);
    check("rst_pip", parallel_ip, 0);
    check("rst_done", done, 0);
    check("rst_err", seq_error, 0);
    check("rst_dat_ready", dat_ready, 0);
    mon_en = 1'b1;

    // Token, with a handshake request held during the busy window.
    issue(2'b00, 4'b1001, 7'b0010110, 4'b0110, '0, b);
    exp_ld(b + 1, 8'h80); exp_ld(b + 9, 8'h69); exp_ld(b + 17, 8'h16); exp_ld(b + 25, 8'h03);
    exp_done.push_back(b + 32);
    @(negedge clock);
    req_kind = 2'b10;
    req_pid  = 4'b0010;
    rdy_hi   = 0;
    while (cyc < b + 40) begin
      if (req_ready === 1'b1) rdy_hi++;
      if (cyc == b + 5) check("tok_busy", busy, 1);
      @(negedge clock);
    end
    check("busy_ready_highs", rdy_hi, 0);
    req_valid = 1'b0;
    expect_ready_at("tok_ready_cycle", b + 49);

    // Handshake.
    issue(2'b10, 4'b0010, 7'h00, 4'h0, '0, b);
    exp_ld(b + 1, 8'h80); exp_ld(b + 9, 8'hD2);
    exp_done.push_back(b + 16);
    release_req();
    expect_ready_at("hs_ready_cycle", b + 33);

    // Data, two payload bytes.
    issue(2'b01, 4'b0011, 7'h00, 4'h0, 7'd2, b);
    pay(1'b1, 8'h62); pay(1'b1, 8'h00);
    exp_drdy.push_back(b + 16); exp_drdy.push_back(b + 24);
    exp_ld(b + 1, 8'h80); exp_ld(b + 9, 8'hC3); exp_ld(b + 17, 8'h62); exp_ld(b + 25, 8'h00);
`ifdef SIE_SEQ_CRC16_PAD_EN
    exp_ld(b + 33, 8'h00); exp_ld(b + 41, 8'h00);
    exp_done.push_back(b + 48);
    release_req();
    expect_ready_at("d2_ready_cycle", b + 65);
`else
    exp_done.push_back(b + 32);
    release_req();
    expect_ready_at("d2_ready_cycle", b + 49);
`endif

    // Data, one payload byte.
    issue(2'b01, 4'b0011, 7'h00, 4'h0, 7'd1, b);
    pay(1'b1, 8'h62);
    exp_drdy.push_back(b + 16);
    exp_ld(b + 1, 8'h80); exp_ld(b + 9, 8'hC3); exp_ld(b + 17, 8'h62);
`ifdef SIE_SEQ_CRC16_PAD_EN
    exp_ld(b + 25, 8'h00); exp_ld(b + 33, 8'h00);
    exp_done.push_back(b + 40);
    release_req();
    expect_ready_at("d1_ready_cycle", b + 57);
`else
    exp_done.push_back(b + 24);
    release_req();
    expect_ready_at("d1_ready_cycle", b + 41);
`endif

    // Data, zero-length payload.
    issue(2'b01, 4'b1011, 7'h00, 4'h0, 7'd0, b);
    exp_ld(b + 1, 8'h80); exp_ld(b + 9, 8'h4B);
`ifdef SIE_SEQ_CRC16_PAD_EN
    exp_ld(b + 17, 8'h00); exp_ld(b + 25, 8'h00);
    exp_done.push_back(b + 32);
    release_req();
    expect_ready_at("d0_ready_cycle", b + 49);
`else
    exp_done.push_back(b + 16);
    release_req();
    expect_ready_at("d0_ready_cycle", b + 33);
`endif

    // Underrun at the second fetch of a three-byte payload.
    issue(2'b01, 4'b0011, 7'h00, 4'h0, 7'd3, b);
    pay(1'b1, 8'hA5); pay(1'b0, 8'h00);
    exp_drdy.push_back(b + 16); exp_drdy.push_back(b + 24);
    exp_ld(b + 1, 8'h80); exp_ld(b + 9, 8'hC3); exp_ld(b + 17, 8'hA5);
    exp_err.push_back(b + 25);
    release_req();
    expect_ready_at("underrun_ready_cycle", b + 41);

    // Reserved kind: error pulse only, straight back to idle.
    issue(2'b11, 4'b0101, 7'h00, 4'h0, '0, b);
    exp_err.push_back(b + 1);
    release_req();
    expect_ready_at("rsvd_ready_cycle", b + 1);

    // Reset during TOK1.
    issue(2'b00, 4'b0001, 7'h55, 4'hF, '0, b);
    exp_ld(b + 1, 8'h80); exp_ld(b + 9, 8'hE1); exp_ld(b + 17, 8'hD5);
    release_req();
    while (cyc < b + 20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_load", load_SIE, 0);
    check("midrst_pip", parallel_ip, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_req_ready", req_ready, 1);
    repeat (40) @(negedge clock);

    check("leftover_loads", exp_load.size(), 0);
    check("leftover_done", exp_done.size(), 0);
    check("leftover_dat_ready", exp_drdy.size(), 0);
    check("leftover_seq_error", exp_err.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
